psx_pad_device: RTL and testbench

- Device/responder end of the PlayStation controller serial link, so the FPGA can emulate a DualShock pad toward an external PSX-protocol host, or loop back to our own controller host for self-test.
- Samples the host's SEL/CLK/CMD lines in the system pixel clock domain, answers the poll command (0x42) with ID, 0x5A, button and analog bytes, and generates ACK pulses.
- Captures the host's vibration bytes.
- Sits beside the joystick front end: buttons and axes come from local logic, vibration bytes go back out.

---
 rtl/psx_pad_device_if.sv | 18 +
 rtl/psx_pad_device.sv | 230 +++++++++++++++++++++++
 tb/tb_psx_pad_device.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psx_pad_device_if.sv
// psx_pad_device_if: the five-wire PlayStation controller link (host <-> pad).
// Latency: none, wires only.
// Backpressure: none; the host paces the link with ps_clk and the pad answers with ps_ack.
// Signals: ps_sel (attention, active-low), ps_clk (idles high), ps_cmd (host->pad, LSB first),
//   ps_dat (pad->host, LSB first, idles 1), ps_ack (active-low acknowledge, idles 1).
// Modports: master = host side, slave = pad side.
interface psx_pad_device_if;
  logic ps_sel;
  logic ps_clk;
  logic ps_cmd;
  logic ps_dat;
  logic ps_ack;

  modport master (output ps_sel, output ps_clk, output ps_cmd,
                  input  ps_dat, input  ps_ack);
  modport slave  (input  ps_sel, input  ps_clk, input  ps_cmd,
                  output ps_dat, output ps_ack);
endinterface

// File: rtl/psx_pad_device.sv
// psx_pad_device: PlayStation pad responder emulating a DualShock toward a PSX-protocol host.
// Latency: link events take effect SYNC_STAGES+1 clk after the pin changes; ACK follows ACK_DELAY clk later.
// Backpressure: none; the host owns ps_clk and the pad answers every edge inside a selected frame.
// Ports: clk, rst (sync, active-high); link (slave side of psx_pad_device_if);
//   buttons[15:0] active-low pad buttons and axes[31:0] (RX,RY,LX,LY), snapshotted at frame start;
//   vib[15:0] = cmd bytes 3/4 of the last completed poll; frame_done = 1-clk pulse at poll end.
// Build option PSX_PAD_ANALOG_EN: defined -> analog pad (ID 0x73, 9-byte frame, axes sent);
//   undefined -> digital pad (ID 0x41, 5-byte frame, axes not sent).
// SYNC_STAGES must be at least 2.
module psx_pad_device #(
  parameter int ACK_DELAY   = 50,
  parameter int ACK_WIDTH   = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  psx_pad_device_if.slave       link,
  input  logic [15:0]           buttons,
  input  logic [31:0]           axes,
  output logic [15:0]           vib,
  output logic                  frame_done
);

`ifdef PSX_PAD_ANALOG_EN
  localparam logic [7:0] PAD_ID = 8'h73;
  localparam logic [3:0] LAST   = 4'd8;
`else
  localparam logic [7:0] PAD_ID = 8'h41;
  localparam logic [3:0] LAST   = 4'd4;
`endif

  localparam int ACK_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int ACW     = $clog2(ACK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, IGNORE, DONE} state_t;
  typedef enum logic [1:0] {ACK_IDLE, ACK_WAIT, ACK_LOW} ack_state_t;

  // ---------------- line synchronizers and edge detect ----------------
  logic [SYNC_STAGES-1:0] sel_sync, clk_sync, cmd_sync;
  logic                   sel_q, clk_q;
  logic                   sel_s, clk_s, cmd_s;
  logic                   sel_fall, sel_rise, clk_fall, clk_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_sync <= '1;
      clk_sync <= '1;
      cmd_sync <= '1;
      sel_q    <= 1'b1;
      clk_q    <= 1'b1;
    end else begin
      sel_sync <= {sel_sync[SYNC_STAGES-2:0], link.ps_sel};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], link.ps_clk};
      cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], link.ps_cmd};
      sel_q    <= sel_s;
      clk_q    <= clk_s;
    end
  end

  assign sel_s    = sel_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cmd_s    = cmd_sync[SYNC_STAGES-1];
  assign sel_fall = sel_q & ~sel_s;
  assign sel_rise = ~sel_q & sel_s;
  assign clk_fall = clk_q & ~clk_s;
  assign clk_rise = ~clk_q & clk_s;

  // ---------------- frame state ----------------
  state_t     state_q, state_d;
  ack_state_t ack_state_q, ack_state_d;
  logic [ACW-1:0] ack_cnt_q, ack_cnt_d;

  logic [2:0]  bitcnt;
  logic [3:0]  byte_idx;
  logic [7:0]  tx_byte, tx_next;
  logic [7:0]  rx_byte, rx_next;
  logic [15:0] snap_btn;
  logic [31:0] snap_axes;
  logic [15:0] shadow, shadow_next;
  logic        ps_dat_q, ps_ack_q;
  logic        byte_done, cmd_bad, is_last, ack_start;

  // Frame-level events (sel edges) win over any clock edge seen in the same cycle.
  assign byte_done = (state_q == ACTIVE) & clk_rise & (bitcnt == 3'd7) & ~sel_rise & ~sel_fall;
  assign cmd_bad   = ((byte_idx == 4'd0) && (rx_next != 8'h01)) ||
                     ((byte_idx == 4'd1) && (rx_next != 8'h42));
  assign is_last   = (byte_idx == LAST);
  assign ack_start = byte_done & ~cmd_bad & ~is_last;

  // Receive byte as it will look once the current cmd bit is shifted in.
  always_comb begin
    rx_next         = rx_byte;
    rx_next[bitcnt] = cmd_s;
  end

  // Reply for the byte after the one now completing.
  always_comb begin
    tx_next = 8'hFF;
    case (byte_idx)
      4'd0:    tx_next = PAD_ID;
      4'd1:    tx_next = 8'h5A;
      4'd2:    tx_next = snap_btn[7:0];
      4'd3:    tx_next = snap_btn[15:8];
      4'd4:    tx_next = snap_axes[7:0];
      4'd5:    tx_next = snap_axes[15:8];
      4'd6:    tx_next = snap_axes[23:16];
      4'd7:    tx_next = snap_axes[31:24];
      default: tx_next = 8'hFF;
    endcase
  end

  // Vibration bytes collect in a shadow and only reach vib when the poll completes.
  always_comb begin
    shadow_next = shadow;
    if (byte_idx == 4'd3) shadow_next[7:0]  = rx_next;
    if (byte_idx == 4'd4) shadow_next[15:8] = rx_next;
  end

  // Main FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Main FSM: next state.
  always_comb begin
    state_d = state_q;
    if (sel_rise) begin
      state_d = IDLE;
    end else if (sel_fall) begin
      state_d = ACTIVE;
    end else if (byte_done) begin
      if (cmd_bad)      state_d = IGNORE;
      else if (is_last) state_d = DONE;
    end
  end

  // ACK FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_state_q <= ACK_IDLE;
      ack_cnt_q   <= '0;
      ps_ack_q    <= 1'b1;
    end else begin
      ack_state_q <= ack_state_d;
      ack_cnt_q   <= ack_cnt_d;
      ps_ack_q    <= (ack_state_d != ACK_LOW);
    end
  end

  // ACK FSM: delay then low pulse. Clock edges do not disturb it; only sel edges cancel it.
  always_comb begin
    ack_state_d = ack_state_q;
    ack_cnt_d   = ack_cnt_q;
    if (sel_rise || sel_fall) begin
      ack_state_d = ACK_IDLE;
      ack_cnt_d   = '0;
    end else if (ack_start) begin
      ack_state_d = ACK_WAIT;
      ack_cnt_d   = ACW'(ACK_DELAY - 1);
    end else begin
      case (ack_state_q)
        ACK_WAIT: begin
          if (ack_cnt_q == '0) begin
            ack_state_d = ACK_LOW;
            ack_cnt_d   = ACW'(ACK_WIDTH - 1);
          end else begin
            ack_cnt_d = ack_cnt_q - 1'b1;
          end
        end
        ACK_LOW: begin
          if (ack_cnt_q == '0) ack_state_d = ACK_IDLE;
          else                 ack_cnt_d   = ack_cnt_q - 1'b1;
        end
        default: ack_state_d = ACK_IDLE;
      endcase
    end
  end

  // Datapath: bit/byte counters, shift registers, snapshot, vib and data line.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt     <= '0;
      byte_idx   <= '0;
      tx_byte    <= 8'hFF;
      rx_byte    <= '0;
      snap_btn   <= '1;
      snap_axes  <= '0;
      shadow     <= '0;
      vib        <= '0;
      frame_done <= 1'b0;
      ps_dat_q   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      if (sel_rise) begin
        ps_dat_q <= 1'b1;
      end else if (sel_fall) begin
        // Snapshot keeps the whole reply coherent even if inputs move mid-frame.
        snap_btn  <= buttons;
        snap_axes <= axes;
        bitcnt    <= '0;
        byte_idx  <= '0;
        tx_byte   <= 8'hFF;
        ps_dat_q  <= 1'b1;
      end else if (state_q == ACTIVE) begin
        if (clk_fall) ps_dat_q <= tx_byte[bitcnt];
        if (clk_rise) begin
          rx_byte <= rx_next;
          bitcnt  <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            byte_idx <= byte_idx + 4'd1;
            tx_byte  <= tx_next;
            shadow   <= shadow_next;
            if (cmd_bad) begin
              ps_dat_q <= 1'b1;
            end else if (is_last) begin
              vib        <= shadow_next;
              frame_done <= 1'b1;
              ps_dat_q   <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign link.ps_dat = ps_dat_q;
  assign link.ps_ack = ps_ack_q;

endmodule

// File: tb/tb_psx_pad_device.sv
// tb_psx_pad_device: bench host polling the pad at 250 kHz (100 clk per bit at 25 MHz).
// Latency: replies and ACK timing are checked against SYNC_STAGES+1+ACK_DELAY clk from the pin edge.
// Backpressure: the host waits out each ACK window before clocking the next byte.
module tb_psx_pad_device;
  localparam int ACK_DELAY   = 50;
  localparam int ACK_WIDTH   = 50;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 50;
  localparam int GAP         = 130;
  localparam int ACK_LAT     = SYNC_STAGES + 1 + ACK_DELAY;
`ifdef PSX_PAD_ANALOG_EN
  localparam int         LAST   = 8;
  localparam logic [7:0] PAD_ID = 8'h73;
`else
  localparam int         LAST   = 4;
  localparam logic [7:0] PAD_ID = 8'h41;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] buttons;
  logic [31:0] axes;
  logic [15:0] vib;
  logic        frame_done;

  psx_pad_device_if link_if();

  psx_pad_device #(
    .ACK_DELAY  (ACK_DELAY),
    .ACK_WIDTH  (ACK_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .link      (link_if),
    .buttons   (buttons),
    .axes      (axes),
    .vib       (vib),
    .frame_done(frame_done)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [71:0] cmd;
    logic [15:0] btn;
    logic [31:0] ax;
    logic [15:0] vib;
    int          fd;
  } vec_t;

  vec_t        vec [5];
  int          checks = 0;
  int          errors = 0;
  int          fd_total = 0;
  logic [7:0]  exp_q [$];
  bit          ack_q [$];

  always @(negedge clk) if (frame_done === 1'b1) fd_total++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int i, input logic [15:0] b, input logic [31:0] a);
    case (i)
      0:       return 8'hFF;
      1:       return PAD_ID;
      2:       return 8'h5A;
      3:       return b[7:0];
      4:       return b[15:8];
      5:       return a[7:0];
      6:       return a[15:8];
      7:       return a[23:16];
      8:       return a[31:24];
      default: return 8'hFF;
    endcase
  endfunction

  // Clock out nbits of cmd; called on a negedge, returns on the negedge of the last rise.
  task automatic xfer_bits(input logic [7:0] cmd, input int nbits, output logic [7:0] rx);
    rx = 8'hFF;
    for (int b = 0; b < nbits; b++) begin
      link_if.ps_clk = 1'b0;
      link_if.ps_cmd = cmd[b];
      repeat (HALF) @(negedge clk);
      rx[b] = link_if.ps_dat;
      link_if.ps_clk = 1'b1;
      if (b != nbits - 1) repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic ack_window(output int first, output int lows);
    first = -1;
    lows  = 0;
    for (int t = 1; t <= GAP; t++) begin
      @(negedge clk);
      if (link_if.ps_ack == 1'b0) begin
        if (first < 0) first = t;
        lows++;
      end
    end
  endtask

  task automatic host_byte(input logic [7:0] cmd, input logic [7:0] exp_b, input bit exp_a,
                           input string name);
    logic [7:0] rx, eb;
    bit         ea;
    int         first, lows;
    exp_q.push_back(exp_b);
    ack_q.push_back(exp_a);
    xfer_bits(cmd, 8, rx);
    ack_window(first, lows);
    eb = exp_q.pop_front();
    ea = ack_q.pop_front();
    check({name, " reply"}, 32'(rx), 32'(eb));
    if (ea) begin
      check({name, " ack delay"}, 32'(first), 32'(ACK_LAT));
      check({name, " ack width"}, 32'(lows), 32'(ACK_WIDTH));
    end else begin
      check({name, " no ack"}, 32'(lows), 32'd0);
    end
  endtask

  task automatic run_frame(input logic [71:0] cmd, input logic [15:0] btn, input logic [31:0] ax,
                           input int chg_idx, input logic [15:0] chg_btn,
                           input logic [15:0] vib_exp, input int fd_exp, input string tag);
    int         fd0;
    bit         ok0, ok1, ea;
    logic [7:0] eb;
    buttons = btn;
    axes    = ax;
    fd0     = fd_total;
    ok0     = (cmd[7:0] == 8'h01);
    ok1     = (cmd[15:8] == 8'h42);
    link_if.ps_sel = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i == chg_idx) buttons = chg_btn;
      if (!ok0) begin
        eb = 8'hFF; ea = 1'b0;
      end else if (!ok1) begin
        eb = (i == 1) ? PAD_ID : 8'hFF;
        ea = (i == 0);
      end else begin
        eb = (i <= LAST) ? model_byte(i, btn, ax) : 8'hFF;
        ea = (i < LAST);
      end
      host_byte(cmd[8*i +: 8], eb, ea, $sformatf("%s byte%0d", tag, i));
    end
    link_if.ps_sel = 1'b1;
    repeat (20) @(negedge clk);
    check({tag, " vib"}, 32'(vib), 32'(vib_exp));
    check({tag, " frame_done count"}, 32'(fd_total - fd0), 32'(fd_exp));
  endtask

  initial begin
    logic [7:0] rx;
    int         fd0, first, lows;

    vec[0] = '{72'h00_00_00_00_55_AA_00_42_01, 16'hBFFE, 32'h80_40_C0_10, 16'h55AA, 1};
    vec[1] = '{72'h00_00_00_00_34_12_00_42_01, 16'h5A3C, 32'h11_22_33_44, 16'h3412, 1};
    vec[2] = '{72'h00_00_00_00_66_77_00_42_81, 16'h0000, 32'hFF_FF_FF_FF, 16'h3412, 0};
    vec[3] = '{72'h00_00_00_00_88_99_00_43_01, 16'h1234, 32'h01_02_03_04, 16'h3412, 0};
    vec[4] = '{72'h00_00_00_00_FF_00_00_42_01, 16'h0000, 32'hFF_FF_FF_FF, 16'hFF00, 1};

    rst            = 1'b1;
    buttons        = 16'hFFFF;
    axes           = 32'h0;
    link_if.ps_sel = 1'b1;
    link_if.ps_clk = 1'b1;
    link_if.ps_cmd = 1'b1;
    repeat (5) @(negedge clk);
    check("reset ps_dat", 32'(link_if.ps_dat), 32'd1);
    check("reset ps_ack", 32'(link_if.ps_ack), 32'd1);
    check("reset vib", 32'(vib), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_frame(vec[v].cmd, vec[v].btn, vec[v].ax, -1, 16'h0, vec[v].vib, vec[v].fd,
                $sformatf("vec%0d", v));

    // Abort after 3 bits of byte 4 (bit 2 of byte 4 is a 0 so the return to 1 is visible).
    buttons = 16'h00FF;
    axes    = 32'h0;
    fd0     = fd_total;
    link_if.ps_sel = 1'b0;
    repeat (HALF) @(negedge clk);
    host_byte(8'h01, 8'hFF, 1'b1, "abort byte0");
    host_byte(8'h42, PAD_ID, 1'b1, "abort byte1");
    host_byte(8'h00, 8'h5A, 1'b1, "abort byte2");
    host_byte(8'hAA, 8'hFF, 1'b1, "abort byte3");
    xfer_bits(8'h55, 3, rx);
    repeat (HALF) @(negedge clk);
    check("abort partial bits", 32'(rx), 32'hF8);
    link_if.ps_sel = 1'b1;
    repeat (SYNC_STAGES) @(negedge clk);
    check("abort dat before action", 32'(link_if.ps_dat), 32'd0);
    @(negedge clk);
    check("abort dat idle", 32'(link_if.ps_dat), 32'd1);
    check("abort ack idle", 32'(link_if.ps_ack), 32'd1);
    repeat (20) @(negedge clk);
    check("abort vib kept", 32'(vib), 32'hFF00);
    check("abort frame_done count", 32'(fd_total - fd0), 32'd0);

    // Buttons change during byte 2: this frame keeps the snapshot, next frame sees the change.
    run_frame(72'h00_00_00_00_A5_5A_00_42_01, 16'hFFFF, 32'h0, 2, 16'h0000, 16'hA55A, 1, "btnchg");
    run_frame(72'h00_00_00_00_3C_C3_00_42_01, 16'h0000, 32'h0, -1, 16'h0000, 16'h3CC3, 1, "btnnext");

    // Pending ACK is cancelled by ps_sel rising during the delay.
    link_if.ps_sel = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer_bits(8'h01, 8, rx);
    check("cancel reply", 32'(rx), 32'hFF);
    repeat (20) @(negedge clk);
    link_if.ps_sel = 1'b1;
    ack_window(first, lows);
    check("cancel no ack", 32'(lows), 32'd0);

    // rst in the middle of an ACK pulse.
    link_if.ps_sel = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer_bits(8'h01, 8, rx);
    first = -1;
    for (int t = 1; t <= ACK_LAT + 10; t++) begin
      @(negedge clk);
      if (link_if.ps_ack == 1'b0) begin
        first = t;
        break;
      end
    end
    check("rst ack start", 32'(first), 32'(ACK_LAT));
    repeat (10) @(negedge clk);
    check("rst ack low before reset", 32'(link_if.ps_ack), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst ps_ack", 32'(link_if.ps_ack), 32'd1);
    check("rst ps_dat", 32'(link_if.ps_dat), 32'd1);
    check("rst vib", 32'(vib), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    link_if.ps_sel = 1'b1;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
